// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, default FIFO depth and a log2 helper.
package uart_pkg;
   localparam int UART_DATA_W = 8;
   localparam int UART_FIFO_DEPTH = 16;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte stream handshake from the receive FIFO to its consumer.
interface uart_rx_fifo_if;
   import uart_pkg::*;
   logic [UART_DATA_W-1:0] m_data;
   logic                   m_valid;
   logic                   m_ready;
   modport master (output m_data, m_valid, input m_ready);
   modport slave  (input m_data, m_valid, output m_ready);
endinterface

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: generic synchronous first-word-fall-through FIFO.
// A write into a full FIFO succeeds only when a read frees the slot in the same cycle.
module uart_fifo_core import uart_pkg::*; #(
   parameter int DW    = UART_DATA_W,
   parameter int DEPTH = UART_FIFO_DEPTH,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic [AW:0]   level_nxt
);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          empty_q, empty_d, wr_ok, rd_ok;
   always_comb begin
      rd_ok    = rd_en & ~empty_q;
      wr_ok    = wr_en & ((level_q != DEPTH_L) | rd_ok);
      wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      empty_d  = level_d == '0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
      end
   always_ff @(posedge clk)
      if (wr_ok) mem[wr_ptr_q] <= wr_data;
   assign rd_data   = mem[rd_ptr_q];
   assign full      = level_q == DEPTH_L;
   assign empty     = empty_q;
   assign level     = level_q;
   assign level_nxt = level_d;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers bytes from the UART receiver, one per rising edge of rx_ready,
// and hands them to the consumer with fill level, almost-full and sticky overflow.
module uart_rx_fifo import uart_pkg::*; #(
   parameter int DEPTH        = UART_FIFO_DEPTH,
   parameter int AW           = clog2(DEPTH),
   parameter int AFULL_THRESH = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rx_ready,
   uart_rx_fifo_if.master         m,
   output logic [AW:0]            level,
   output logic                   almost_full,
   output logic                   overflow,
   input  logic                   clr_overflow
);
   localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_THRESH);
   logic          rx_ready_q, rx_ready_d, almost_full_q, almost_full_d, overflow_q, overflow_d;
   logic          wr_req, rd_req, drop, full, empty;
   logic [AW:0]   level_nxt;
   uart_fifo_core #(.DW(UART_DATA_W), .DEPTH(DEPTH), .AW(AW)) u_core (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_req),
      .wr_data   (rx_data),
      .rd_en     (rd_req),
      .rd_data   (m.m_data),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .level_nxt (level_nxt)
   );
   always_comb begin
      rx_ready_d    = rx_ready;
      wr_req        = rx_ready & ~rx_ready_q;
      rd_req        = ~empty & m.m_ready;
      drop          = wr_req & full & ~rd_req;
      almost_full_d = level_nxt >= AFULL_L;
      overflow_d    = drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
   end
   // rx_ready_q resets high so a level held across reset is not seen as an edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rx_ready_q    <= 1'b1;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         rx_ready_q    <= rx_ready_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
      end
   assign m.m_valid   = ~empty;
   assign almost_full = almost_full_q;
   assign overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random stimulus checked against a queue-based model.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   logic       clk = 0, rst = 1, rx_ready = 1, clr_overflow = 0;
   logic [7:0] rx_data = 0;
   logic [4:0] level;
   logic       almost_full, overflow;
   int         checks = 0, errors = 0;
   byte unsigned q[$];
   byte unsigned fill_data[16];
   bit         m_prev = 1, m_ovf = 0;
   uart_rx_fifo_if mi();
   uart_rx_fifo dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .m            (mi),
      .level        (level),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, ":level"}, 32'(level), 32'(q.size()));
      chk({tag, ":valid"}, 32'(mi.m_valid), 32'(q.size() != 0));
      chk({tag, ":afull"}, 32'(almost_full), 32'(q.size() >= AF));
      chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) chk({tag, ":data"}, 32'(mi.m_data), 32'(q[0]));
   endtask
   // model: a read frees a slot before the write is judged; drop beats clear
   task automatic tick(input string tag);
      bit wr, rd;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_ovf  = 0;
         m_prev = 1;
      end else begin
         wr = rx_ready && !m_prev;
         m_prev = rx_ready;
         rd = q.size() != 0 && mi.m_ready;
         if (rd) void'(q.pop_front());
         if (wr && q.size() < DEPTH) q.push_back(rx_data);
         else if (wr) m_ovf = 1;
         else if (clr_overflow) m_ovf = 0;
      end
      @(negedge clk);
      check_all(tag);
   endtask
   task automatic send(input logic [7:0] b, input string tag);
      rx_ready = 0;
      tick(tag);
      rx_data  = b;
      rx_ready = 1;
      tick(tag);
   endtask
   task automatic drain(input int n);
      mi.m_ready = 1;
      repeat (n) tick("drain");
      mi.m_ready = 0;
   endtask
   initial begin
      logic [7:0] basic [3];
      basic = '{8'h55, 8'hA3, 8'h0F};
      mi.m_ready = 0;
      repeat (3) tick("in_rst");
      rst = 0;
      repeat (10) tick("post_rst");
      chk("post_rst_level", 32'(level), 0);
      foreach (basic[i]) begin
         send(basic[i], "basic");
         if (i == 0) begin
            chk("first_valid", 32'(mi.m_valid), 1);
            chk("first_data", 32'(mi.m_data), 32'h55);
         end
      end
      chk("basic_level", 32'(level), 3);
      mi.m_ready = 1;
      foreach (basic[i]) begin
         chk("basic_out", 32'(mi.m_data), 32'(basic[i]));
         tick("basic_rd");
      end
      mi.m_ready = 0;
      chk("basic_empty_valid", 32'(mi.m_valid), 0);
      chk("basic_empty_level", 32'(level), 0);
      send(8'h7E, "hold");
      repeat (20) tick("hold");
      chk("hold_level", 32'(level), 1);
      drain(1);
      for (int i = 0; i < 16; i++) begin
         fill_data[i] = 8'($urandom);
         send(fill_data[i], "fill");
         chk("fill_afull", 32'(almost_full), 32'(i + 1 >= AF));
      end
      chk("fill_level", 32'(level), 16);
      send(8'hEE, "drop");
      chk("drop_ovf", 32'(overflow), 1);
      chk("drop_level", 32'(level), 16);
      mi.m_ready = 1;
      for (int i = 0; i < 16; i++) begin
         chk("fill_order", 32'(mi.m_data), 32'(fill_data[i]));
         tick("fill_rd");
      end
      mi.m_ready = 0;
      chk("fill_drained", 32'(mi.m_valid), 0);
      clr_overflow = 1;
      tick("clr");
      clr_overflow = 0;
      chk("clr_ovf", 32'(overflow), 0);
      for (int i = 0; i < 16; i++) send(8'($urandom), "fill2");
      rx_ready = 0;
      tick("simul");
      rx_data    = 8'h99;
      rx_ready   = 1;
      mi.m_ready = 1;
      tick("simul");
      mi.m_ready = 0;
      chk("simul_level", 32'(level), 16);
      chk("simul_ovf", 32'(overflow), 0);
      drain(15);
      chk("simul_last", 32'(mi.m_data), 32'h99);
      chk("simul_last_level", 32'(level), 1);
      drain(1);
      for (int i = 0; i < 16; i++) send(8'($urandom), "fill3");
      rx_ready = 0;
      tick("drop_clr");
      rx_data      = 8'hEE;
      rx_ready     = 1;
      clr_overflow = 1;
      tick("drop_clr");
      clr_overflow = 0;
      chk("drop_clr_ovf", 32'(overflow), 1);
      clr_overflow = 1;
      tick("clr2");
      clr_overflow = 0;
      chk("clr2_ovf", 32'(overflow), 0);
      drain(16);
      repeat (400) begin
         rx_ready     = 1'($urandom_range(0, 1));
         rx_data      = 8'($urandom);
         mi.m_ready   = $urandom_range(0, 3) == 0;
         clr_overflow = $urandom_range(0, 15) == 0;
         tick("rand");
      end
      clr_overflow = 0;
      rx_ready     = 0;
      drain(20);
      for (int i = 0; i < 5; i++) send(8'($urandom), "pre_rst");
      chk("pre_rst_level", 32'(level), 5);
      #2 rst = 1;
      #1;
      chk("async_level", 32'(level), 0);
      chk("async_valid", 32'(mi.m_valid), 0);
      tick("rst2");
      rst = 0;
      repeat (3) tick("after_rst2");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
